// File: rtl/cpu_datamem_pkg.sv
// rtl/cpu_datamem_pkg.sv - shared state type and address helper for the CPU/accelerator data memory
package cpu_datamem_pkg;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  // Byte address of base+offset, wrapped into an addr_w-bit space.
  function automatic logic [31:0] wrap_addr(input logic [31:0] base,
                                            input logic [31:0] offset,
                                            input int unsigned addr_w);
    logic [31:0] mask;
    mask = (addr_w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << addr_w) - 32'h1);
    return (base + offset) & mask;
  endfunction

endpackage

// File: rtl/cpu_datamem_arbiter.sv
// rtl/cpu_datamem_arbiter.sv - fixed-priority CPU/accelerator arbiter with anti-starvation counter
module cpu_datamem_arbiter
  import cpu_datamem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  state_t state,
  input  logic   cpu_req,
  input  logic   acc_req,
  output logic   cpu_gnt,
  output logic   acc_gnt
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q;
  logic             starved;
  logic             acc_wins;

  assign starved  = (starve_q == CNT_W'(STARVE_MAX));
  // CPU has priority unless the accelerator has already been blocked STARVE_MAX times in a row.
  assign acc_wins = acc_req && (!cpu_req || starved);
  assign cpu_gnt  = (state == RUN) && cpu_req && !acc_wins;
  assign acc_gnt  = (state == RUN) && acc_wins;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (!acc_req || acc_gnt) begin
      starve_q <= '0;
    end else if (!starved) begin
      starve_q <= starve_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cpu_datamem_arb.sv
// rtl/cpu_datamem_arb.sv - byte-addressable data memory shared by the CPU and the SHA accelerator
module cpu_datamem_arb
  import cpu_datamem_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int CPU_BYTES  = 4,
  parameter int ACC_BYTES  = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [8*CPU_BYTES-1:0] cpu_wdata,
  input  logic [CPU_BYTES-1:0]   cpu_be,
  output logic                   cpu_gnt,
  output logic                   cpu_rvalid,
  output logic [8*CPU_BYTES-1:0] cpu_rdata,
  input  logic                   acc_req,
  input  logic                   acc_we,
  input  logic [ADDR_W-1:0]      acc_addr,
  input  logic [8*ACC_BYTES-1:0] acc_wdata,
  input  logic [ACC_BYTES-1:0]   acc_be,
  output logic                   acc_gnt,
  output logic                   acc_rvalid,
  output logic [8*ACC_BYTES-1:0] acc_rdata,
  output logic                   init_done
);

  localparam int MEM_BYTES = 2 ** ADDR_W;

  logic [7:0] mem [MEM_BYTES];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              clr_last;

  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_base;
  logic [8*ACC_BYTES-1:0] wr_data;
  logic [ACC_BYTES-1:0]   wr_be;
  logic [ADDR_W-1:0]      wr_idx [ACC_BYTES];

  logic [ADDR_W-1:0]      rd_base;
  logic [ADDR_W-1:0]      rd_idx [ACC_BYTES];
  logic [8*ACC_BYTES-1:0] rd_bytes;

  cpu_datamem_arbiter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arbiter (
    .clk    (clk),
    .rst_n  (rst_n),
    .state  (state_q),
    .cpu_req(cpu_req),
    .acc_req(acc_req),
    .cpu_gnt(cpu_gnt),
    .acc_gnt(acc_gnt)
  );

  assign init_done = (state_q == RUN);
  assign clr_last  = (clr_ptr_q == ADDR_W'(MEM_BYTES - ACC_BYTES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + ADDR_W'(ACC_BYTES);
        if (clr_last) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // Single write port: the clear sweep owns it in CLEAR, otherwise the granted writer.
  always_comb begin
    wr_en   = 1'b0;
    wr_base = '0;
    wr_data = '0;
    wr_be   = '0;
    if (state_q == CLEAR) begin
      wr_en   = 1'b1;
      wr_base = clr_ptr_q;
      wr_be   = '1;
    end else if (cpu_gnt && cpu_we) begin
      wr_en                      = 1'b1;
      wr_base                    = cpu_addr;
      wr_data[8*CPU_BYTES-1:0]   = cpu_wdata;
      wr_be[CPU_BYTES-1:0]       = cpu_be;
    end else if (acc_gnt && acc_we) begin
      wr_en   = 1'b1;
      wr_base = acc_addr;
      wr_data = acc_wdata;
      wr_be   = acc_be;
    end
  end

  assign rd_base = cpu_gnt ? cpu_addr : acc_addr;

  always_comb begin
    for (int i = 0; i < ACC_BYTES; i++) begin
      wr_idx[i] = ADDR_W'(wrap_addr(32'(wr_base), 32'(i), ADDR_W));
      rd_idx[i] = ADDR_W'(wrap_addr(32'(rd_base), 32'(i), ADDR_W));
    end
  end

  always_comb begin
    rd_bytes = '0;
    for (int i = 0; i < ACC_BYTES; i++) begin
      rd_bytes[8*i +: 8] = mem[rd_idx[i]];
    end
  end

  // Array contents are not reset; the clear sweep zeroes them after every reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      for (int i = 0; i < ACC_BYTES; i++) begin
        if (wr_be[i]) mem[wr_idx[i]] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      acc_rvalid <= 1'b0;
      acc_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt && !cpu_we;
      acc_rvalid <= acc_gnt && !acc_we;
      if (cpu_gnt && !cpu_we) cpu_rdata <= rd_bytes[8*CPU_BYTES-1:0];
      if (acc_gnt && !acc_we) acc_rdata <= rd_bytes;
    end
  end

endmodule

// File: tb/tb_cpu_datamem_arb.sv
// tb/tb_cpu_datamem_arb.sv - directed self-checking bench for cpu_datamem_arb
module tb_cpu_datamem_arb;

  localparam int ADDR_W     = 16;
  localparam int CPU_BYTES  = 4;
  localparam int ACC_BYTES  = 64;
  localparam int STARVE_MAX = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   cpu_req, cpu_we;
  logic [ADDR_W-1:0]      cpu_addr;
  logic [8*CPU_BYTES-1:0] cpu_wdata;
  logic [CPU_BYTES-1:0]   cpu_be;
  logic                   cpu_gnt, cpu_rvalid;
  logic [8*CPU_BYTES-1:0] cpu_rdata;
  logic                   acc_req, acc_we;
  logic [ADDR_W-1:0]      acc_addr;
  logic [8*ACC_BYTES-1:0] acc_wdata;
  logic [ACC_BYTES-1:0]   acc_be;
  logic                   acc_gnt, acc_rvalid;
  logic [8*ACC_BYTES-1:0] acc_rdata;
  logic                   init_done;

  int total = 0;
  int bad   = 0;

  logic [8*ACC_BYTES-1:0] pattern;
  int                     run_len, max_run;

  always #5 clk = ~clk;

  cpu_datamem_arb #(
    .ADDR_W(ADDR_W), .CPU_BYTES(CPU_BYTES), .ACC_BYTES(ACC_BYTES), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_be(acc_be), .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
    .init_done(init_done)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_init(input string tag);
    int n;
    bit saw_gnt;
    n       = 0;
    saw_gnt = 1'b0;
    while (!init_done && n < 1100) begin
      #3;
      if (cpu_gnt || acc_gnt) saw_gnt = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_cycles"}, n, 1024);
    chk({tag, "_gnt_in_clear"}, saw_gnt, 0);
  endtask

  task automatic cpu_access(input string tag, input logic we, input logic [15:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            input logic [31:0] exp_rdata);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    #1;
    chk({tag, "_gnt"}, cpu_gnt, 1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    if (!we) begin
      chk({tag, "_rvalid"}, cpu_rvalid, 1);
      chk({tag, "_rdata"}, cpu_rdata, exp_rdata);
    end
  endtask

  task automatic acc_access(input string tag, input logic we, input logic [15:0] addr,
                            input logic [511:0] wdata, input logic [63:0] be,
                            input logic [511:0] exp_rdata);
    acc_req = 1'b1; acc_we = we; acc_addr = addr; acc_wdata = wdata; acc_be = be;
    #1;
    chk({tag, "_gnt"}, acc_gnt, 1);
    @(posedge clk); #1;
    acc_req = 1'b0;
    if (!we) begin
      chk({tag, "_rvalid"}, acc_rvalid, 1);
      chk({tag, "_rdata"}, acc_rdata, exp_rdata);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    acc_req = 1'b1; acc_we = 1'b0; acc_addr = '0; acc_wdata = '0; acc_be = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_acc_gnt", acc_gnt, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_acc_rvalid", acc_rvalid, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_acc_rdata", acc_rdata, 0);
    chk("rst_init_done", init_done, 0);

    // Clear sweep with both ports requesting throughout.
    rst_n = 1'b1;
    wait_init("init");
    cpu_req = 1'b0; acc_req = 1'b0;
    @(posedge clk); #1;
    cpu_access("rd_fffc", 1'b0, 16'hFFFC, 32'h0, 4'h0, 32'h0000_0000);
    @(posedge clk); #1;
    chk("rd_fffc_pulse", cpu_rvalid, 0);

    // Byte-enabled CPU write.
    cpu_access("wr_1000", 1'b1, 16'h1000, 32'hDEAD_BEEF, 4'b0101, 32'h0);
    cpu_access("rd_1000", 1'b0, 16'h1000, 32'h0, 4'h0, 32'h00AD_00EF);

    // Accelerator write wrapping past the top of the array.
    for (int i = 0; i < ACC_BYTES; i++) pattern[8*i +: 8] = 8'(i);
    acc_access("acc_wr_fff0", 1'b1, 16'hFFF0, pattern, '1, '0);
    cpu_access("rd_wrap_0000", 1'b0, 16'h0000, 32'h0, 4'h0, 32'h1312_1110);
    cpu_access("rd_wrap_fffc", 1'b0, 16'hFFFC, 32'h0, 4'h0, 32'h0F0E_0D0C);
    acc_access("acc_rd_fff0", 1'b0, 16'hFFF0, '0, '0, pattern);

    // Continuous contention: CPU x4 then accelerator x1.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0000;
    acc_req = 1'b1; acc_we = 1'b0; acc_addr = 16'h0000;
    run_len = 0; max_run = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("arb_%0d", k), {cpu_gnt, acc_gnt}, (k % 5 == 4) ? 2'b01 : 2'b10);
      if (acc_gnt) run_len = 0;
      else run_len++;
      if (run_len > max_run) max_run = run_len;
      @(posedge clk); #1;
    end
    chk("arb_max_block", max_run, 4);
    cpu_req = 1'b0; acc_req = 1'b0;
    @(posedge clk); #1;

    // Read-after-write in the very next cycle.
    cpu_access("raw_wr_5000", 1'b1, 16'h5000, 32'h4433_2211, 4'hF, 32'h0);
    cpu_access("raw_rd_5002", 1'b0, 16'h5002, 32'h0, 4'h0, 32'h0000_4433);
    @(posedge clk); #1;
    chk("raw_rvalid_pulse", cpu_rvalid, 0);

    // Reset while an accelerator read is being granted.
    acc_req = 1'b1; acc_we = 1'b0; acc_addr = 16'hFFF0;
    rst_n = 1'b0;
    #1;
    chk("rst_flight_gnt", acc_gnt, 1);
    @(posedge clk); #1;
    acc_req = 1'b0;
    rst_n   = 1'b1;
    chk("rst_flight_rvalid", acc_rvalid, 0);
    chk("rst_flight_rdata", acc_rdata, 0);
    chk("rst_flight_init_done", init_done, 0);
    wait_init("reinit");
    cpu_access("rd_5000_cleared", 1'b0, 16'h5000, 32'h0, 4'h0, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_datamem_arb.md
Name: cpu_datamem_arb

Overview:
Parametrised, byte-addressable data memory shared by the CPU and the SHA accelerator. It has one physical access per cycle and two requester ports with valid/ready handshakes. Each port supports byte-enabled writes and wide reads. A fixed-priority arbiter with an anti-starvation counter selects the requester. A sequential clear FSM zeroes the array after reset.

Parameters:
ADDR_W, 16, byte-address width; array holds 2**ADDR_W bytes
CPU_BYTES, 4, CPU data width in bytes (read and write)
ACC_BYTES, 64, accelerator data width in bytes (read and write); must be a power of 2 and at least CPU_BYTES
STARVE_MAX, 4, consecutive accelerator-blocked cycles before the accelerator gains priority

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
cpu_req  in  1  CPU request valid
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU byte address
cpu_wdata  in  8*CPU_BYTES  CPU write data; byte i goes to addr+i
cpu_be  in  CPU_BYTES  CPU byte enables
cpu_gnt  out  1  CPU request accepted this cycle
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  8*CPU_BYTES  CPU read data; byte i = mem[addr+i]
acc_req, acc_we, acc_addr, acc_wdata, acc_be, acc_gnt, acc_rvalid, acc_rdata  same roles as the CPU ports, sized with ACC_BYTES
init_done  out  1  high once the clear sequence has finished

Behaviour:
- Reset values: all gnt=0, all rvalid=0, all rdata=0, init_done=0, starve counter=0, clear pointer=0, state=CLEAR.
- State CLEAR:
  - Each cycle, zero ACC_BYTES bytes at the pointer, then advance the pointer by ACC_BYTES.
  - After the last block, go to RUN and set init_done=1. Default depth takes 1024 cycles.
  - Both gnt outputs are held at 0 in CLEAR.
- State RUN: no exit except reset. rst_n low at any time returns to CLEAR, restarts the pointer at 0, and drops in-flight rvalid.
- Grant is combinational from req and state. Grant means the request is consumed this cycle. A requester must hold req, addr, and data stable until granted.
- Arbitration: at most one gnt per cycle.
  - CPU wins by default.
  - When both request, the accelerator loses, and the starve counter is already at STARVE_MAX, the accelerator wins instead and the counter clears.
  - The counter increments on each cycle where acc_req=1 and acc_gnt=0, saturating at STARVE_MAX. It clears whenever acc_gnt=1 or acc_req=0.
- Write: for each byte i with be[i]=1, mem[(addr+i) mod 2**ADDR_W] <= wdata byte i at the clock edge. Bytes with be[i]=0 are unchanged. The address wraps and never faults.
- Read: latency is 1.
  - The cycle after a granted read, that port's rvalid=1 and rdata holds the bytes from the wrapped address.
  - rvalid is a one-cycle pulse.
  - rdata holds its last value otherwise.
  - Only the granted port's outputs change.
- Ordering: a read granted in the cycle after a write to overlapping bytes returns the new data. Same-cycle read/write conflict cannot occur because only one grant is issued.
- A write request has be ignored when we=0. A request with we=1 and be=0 is granted and is a no-op.

Decomposition:
- Package cpu_datamem_pkg: state enum {CLEAR, RUN}, plus helper function wrap_addr(base, offset).
- Sub-module cpu_datamem_arbiter: priority and starvation counter logic; inputs are the two req signals and state, outputs are the two gnt signals.
- The array, clear FSM, and read registers stay in the top module.

Test Plan:
- Reset, then hold rst_n=1 for 1024 cycles → init_done rises on cycle 1024. Gnt stays 0 throughout even with both req=1. A CPU read of 0xFFFC afterwards returns 0.
- CPU writes 0xDEADBEEF at 0x1000 with be=4'b0101, then reads 0x1000 → rdata=0x00AD00EF one cycle after grant.
- Accel writes 64 bytes of value n (n=0..63) at 0xFFF0, then the CPU reads 0x0000 → wraps correctly, rdata=0x13121110.
- Both ports request continuously with STARVE_MAX=4 → grant pattern is CPU×4, ACC×1, repeating. The accelerator is never blocked for more than 4 consecutive cycles.
- CPU write at 0x5000 granted, then a read of 0x5002 next cycle → returns the new bytes (read-after-write) with rvalid exactly 1 cycle.
- Assert rst_n=0 for one cycle in RUN while an accel read is in flight → acc_rvalid stays 0, init_done=0, and the clear sequence restarts.
